// File: rtl/dsp_dma_pkg.sv
// ============================================================================
// Module      : dsp_dma_pkg
// Description : Shared defaults, state encoding and helpers for the DSP DMA
//               engines (dma_controller / dma_input_controller).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_dma_pkg;

    localparam int DATA_WIDTH_DEF = 12;
    localparam int BLOCK_SIZE_DEF = 64;
    localparam int DROP_CNT_W     = 16;

    typedef logic [1:0] dma_state_t;

    localparam dma_state_t ST_IDLE = 2'd0;
    localparam dma_state_t ST_RECV = 2'd1;
    localparam dma_state_t ST_FULL = 2'd2;

    // A single-word block still needs a 1-bit pointer.
    function automatic int ptr_width(input int block_size);
        return (block_size > 1) ? $clog2(block_size) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_sat_counter.sv
// ============================================================================
// Module      : dma_sat_counter
// Description : Width-parameterised up-counter that saturates at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/dma_input_controller.sv
// ============================================================================
// Module      : dma_input_controller
// Description : Inbound DMA engine; packs BLOCK_SIZE stream words into a flat
//               buffer and holds it until the core acknowledges.
//               Optional dropped-word counter: define DMA_IN_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_input_controller
    import dsp_dma_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int PTR_W      = ptr_width(BLOCK_SIZE)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_dma_in,
    input  logic                             abort,
    input  logic [DATA_WIDTH-1:0]            dma_data_in,
    input  logic                             dma_valid_in,
    output logic                             dma_ready,
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0] input_buffer_flat,
    output logic                             block_valid,
    output logic                             dma_in_done,
    input  logic                             block_ack,
    output logic [PTR_W-1:0]                 dma_in_ptr,
    output logic [DROP_CNT_W-1:0]            drop_count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_SIZE - 1);

    dma_state_t                        state_q, state_d;
    logic [PTR_W-1:0]                  ptr_q, ptr_d;
    logic [DATA_WIDTH*BLOCK_SIZE-1:0]  buf_q, buf_d;
    logic                              done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_dma_in) begin
                    state_d = ST_RECV;
                    ptr_d   = '0;
                end
            end
            ST_RECV: begin
                // Abort outranks a same-cycle accept, so the word is discarded.
                if (abort) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else if (dma_valid_in) begin
                    for (int k = 0; k < BLOCK_SIZE; k++) begin
                        if (ptr_q == PTR_W'(k)) begin
                            buf_d[DATA_WIDTH*(BLOCK_SIZE-k)-1 -: DATA_WIDTH] = dma_data_in;
                        end
                    end
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_FULL;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_FULL: begin
                if (block_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    assign dma_ready         = (state_q == ST_RECV);
    assign block_valid       = (state_q == ST_FULL);
    assign dma_in_done       = done_q;
    assign dma_in_ptr        = ptr_q;
    assign input_buffer_flat = buf_q;

`ifdef DMA_IN_DROP_CNT_EN
    logic drop_en;
    assign drop_en = dma_valid_in && !dma_ready;

    dma_sat_counter #(
        .WIDTH (DROP_CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (drop_en),
        .count (drop_count)
    );
`else
    assign drop_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dma_input_controller.sv
// ============================================================================
// Module      : tb_dma_input_controller
// Description : Directed self-checking bench with a slice scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_input_controller;

    localparam int DW = 12;
    localparam int BS = 8;
    localparam int PW = 3;
    localparam int BW = DW * BS;
`ifdef DMA_IN_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_dma_in;
    logic          abort;
    logic [DW-1:0] dma_data_in;
    logic          dma_valid_in;
    logic          dma_ready;
    logic [BW-1:0] input_buffer_flat;
    logic          block_valid;
    logic          dma_in_done;
    logic          block_ack;
    logic [PW-1:0] dma_in_ptr;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    dma_input_controller #(
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start_dma_in      (start_dma_in),
        .abort             (abort),
        .dma_data_in       (dma_data_in),
        .dma_valid_in      (dma_valid_in),
        .dma_ready         (dma_ready),
        .input_buffer_flat (input_buffer_flat),
        .block_valid       (block_valid),
        .dma_in_done       (dma_in_done),
        .block_ack         (block_ack),
        .dma_in_ptr        (dma_in_ptr),
        .drop_count        (drop_count)
    );

    typedef struct packed {
        logic [PW-1:0] idx;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb_q[$];
    logic [DW-1:0] model [BS];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            exp_drop = 0;

    function automatic logic [BW-1:0] model_flat();
        logic [BW-1:0] f;
        f = '0;
        for (int k = 0; k < BS; k++) f[DW*(BS-k)-1 -: DW] = model[k];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Retire accepted words into the model; optionally compare the buffer.
    task automatic sb_drain(input bit compare, input string tag);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            model[e.idx] = e.data;
        end
        if (compare) chk(tag, 128'(input_buffer_flat), 128'(model_flat()));
    endtask

    task automatic send(input int idx, input logic [DW-1:0] d);
        dma_valid_in = 1'b1;
        dma_data_in  = d;
        sb_q.push_back(sb_t'{idx: PW'(idx), data: d});
        cyc();
    endtask

    task automatic start_block(input string tag);
        start_dma_in = 1'b1;
        cyc();
        start_dma_in = 1'b0;
        chk({tag, "_ready"}, 128'(dma_ready), 128'(1));
        chk({tag, "_ptr0"}, 128'(dma_in_ptr), 128'(0));
    endtask

    task automatic stream_block(input string tag, input int base, input int step);
        for (int i = 0; i < BS; i++) begin
            send(i, DW'(base + step * i));
            if (i < BS - 1) begin
                chk({tag, "_ptr"}, 128'(dma_in_ptr), 128'(i + 1));
            end
        end
        dma_valid_in = 1'b0;
        chk({tag, "_done"}, 128'(dma_in_done), 128'(1));
        chk({tag, "_bvalid"}, 128'(block_valid), 128'(1));
        chk({tag, "_ready_lo"}, 128'(dma_ready), 128'(0));
        chk({tag, "_ptr_wrap"}, 128'(dma_in_ptr), 128'(0));
        sb_drain(1'b1, {tag, "_buf"});
    endtask

    task automatic ack_block(input string tag);
        block_ack = 1'b1;
        cyc();
        block_ack = 1'b0;
        chk({tag, "_ack_idle"}, 128'(block_valid), 128'(0));
    endtask

    logic [BW-1:0] basic_exp;
    logic [BW-1:0] held;

    initial begin
        basic_exp = {12'd100, 12'd200, 12'd300, 12'd400, 12'd500, 12'd600, 12'd700, 12'd800};
        for (int k = 0; k < BS; k++) model[k] = '0;
        reset        = 1'b0;
        start_dma_in = 1'b0;
        abort        = 1'b0;
        dma_data_in  = '0;
        dma_valid_in = 1'b0;
        block_ack    = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", 128'(dma_ready), 128'(0));
        chk("rst_bvalid", 128'(block_valid), 128'(0));
        chk("rst_done", 128'(dma_in_done), 128'(0));
        chk("rst_ptr", 128'(dma_in_ptr), 128'(0));
        chk("rst_buf", 128'(input_buffer_flat), 128'(0));
        chk("rst_drop", 128'(drop_count), 128'(0));
        reset = 1'b1;
        cyc();

        // Basic block
        start_block("basic");
        stream_block("basic", 100, 100);
        chk("basic_const", 128'(input_buffer_flat), 128'(basic_exp));
        cyc();
        chk("basic_done_pulse", 128'(dma_in_done), 128'(0));
        chk("basic_hold", 128'(block_valid), 128'(1));
        ack_block("basic");

        // Gapped valid with an ignored mid-block start
        start_block("gap");
        for (int i = 0; i < BS; i++) begin
            start_dma_in = (i == 3);
            send(i, DW'(100 + 100 * i));
            start_dma_in = 1'b0;
            if (i < BS - 1) begin
                dma_valid_in = 1'b0;
                dma_data_in  = 12'hABC;
                cyc();
                chk("gap_ptr_hold", 128'(dma_in_ptr), 128'(i + 1));
            end else begin
                dma_valid_in = 1'b0;
                chk("gap_done", 128'(dma_in_done), 128'(1));
            end
        end
        sb_drain(1'b1, "gap_buf");
        chk("gap_const", 128'(input_buffer_flat), 128'(basic_exp));

        // Backpressure in FULL: words dropped, buffer stable
        held = input_buffer_flat;
        for (int i = 0; i < 3; i++) begin
            dma_valid_in = 1'b1;
            dma_data_in  = 12'hFFF;
            exp_drop++;
            cyc();
        end
        dma_valid_in = 1'b0;
        chk("bp_buf_stable", 128'(input_buffer_flat), 128'(held));
        chk("bp_bvalid", 128'(block_valid), 128'(1));
        chk("bp_drop", 128'(drop_count), 128'(DROP_EN ? exp_drop : 0));
        ack_block("bp");
        start_block("bp2");
        stream_block("bp2", 1000, 111);
        ack_block("bp2");

        // Abort after four words: partial data retained, no completion
        start_block("abort");
        for (int i = 0; i < 4; i++) send(i, DW'(50 + i));
        dma_valid_in = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_ready", 128'(dma_ready), 128'(0));
        chk("abort_ptr", 128'(dma_in_ptr), 128'(0));
        chk("abort_bvalid", 128'(block_valid), 128'(0));
        chk("abort_done", 128'(dma_in_done), 128'(0));
        sb_drain(1'b1, "abort_partial");
        start_block("after_abort");
        stream_block("after_abort", 7, 9);
        ack_block("after_abort");

        // Abort coincident with the final accept
        start_block("abort_last");
        for (int i = 0; i < BS - 1; i++) send(i, DW'(2000 + i));
        abort        = 1'b1;
        dma_valid_in = 1'b1;
        dma_data_in  = 12'h5A5;
        cyc();
        abort        = 1'b0;
        dma_valid_in = 1'b0;
        chk("abort_last_done", 128'(dma_in_done), 128'(0));
        chk("abort_last_bvalid", 128'(block_valid), 128'(0));
        chk("abort_last_ptr", 128'(dma_in_ptr), 128'(0));
        sb_drain(1'b1, "abort_last_buf");
        cyc();
        chk("abort_last_done2", 128'(dma_in_done), 128'(0));

        // block_ack together with start in FULL
        start_block("ackstart");
        stream_block("ackstart", 300, 5);
        block_ack    = 1'b1;
        start_dma_in = 1'b1;
        cyc();
        block_ack    = 1'b0;
        start_dma_in = 1'b0;
        chk("ackstart_bvalid", 128'(block_valid), 128'(0));
        chk("ackstart_ready", 128'(dma_ready), 128'(0));
        cyc();
        chk("ackstart_ready2", 128'(dma_ready), 128'(0));
        chk("ackstart_drop", 128'(drop_count), 128'(DROP_EN ? exp_drop : 0));

        // Asynchronous reset in the middle of RECV
        start_block("midrst");
        for (int i = 0; i < 3; i++) send(i, DW'(900 + i));
        dma_valid_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        sb_q.delete();
        for (int k = 0; k < BS; k++) model[k] = '0;
        exp_drop = 0;
        chk("midrst_ready", 128'(dma_ready), 128'(0));
        chk("midrst_ptr", 128'(dma_in_ptr), 128'(0));
        chk("midrst_buf", 128'(input_buffer_flat), 128'(0));
        chk("midrst_drop", 128'(drop_count), 128'(0));
        chk("midrst_bvalid", 128'(block_valid), 128'(0));
        reset = 1'b1;
        cyc();
        dma_valid_in = 1'b1;
        dma_data_in  = 12'h123;
        exp_drop++;
        cyc();
        dma_valid_in = 1'b0;
        chk("postrst_ready", 128'(dma_ready), 128'(0));
        chk("postrst_ptr", 128'(dma_in_ptr), 128'(0));
        chk("postrst_buf", 128'(input_buffer_flat), 128'(0));
        chk("postrst_drop", 128'(drop_count), 128'(DROP_EN ? exp_drop : 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
